// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_port_arbiter
//  Purpose  : Shares one external memory bus between the instruction-fetch
//             (IF) port and the data-access (MEM) port of the MIPS core.
//             MEM has priority, with a starvation limit that forces an IF
//             grant. Every bus transaction is registered, and each
//             transaction is followed by one IDLE turnaround cycle.
//  Options  : define ARB_TIMEOUT_EN to abort a bus cycle after TIMEOUT
//             cycles without bus_ack (pulses bus_err, returns rdata = 0).
//  Revision : 1.0  initial release
// ============================================================================
module mem_port_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int STARVE_MAX = 2,
   parameter int TIMEOUT    = 16
) (
   input  logic                clk,
   input  logic                rst,
   // instruction fetch port
   input  logic                if_req,
   input  logic [ADDR_W-1:0]   if_addr,
   output logic [DATA_W-1:0]   if_rdata,
   output logic                if_ready,
   // data access port
   input  logic                mem_req,
   input  logic                mem_we,
   input  logic [DATA_W/8-1:0] mem_sel,
   input  logic [ADDR_W-1:0]   mem_addr,
   input  logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W-1:0]   mem_rdata,
   output logic                mem_ready,
   // external memory bus
   output logic                bus_req,
   output logic                bus_we,
   output logic [DATA_W/8-1:0] bus_sel,
   output logic [ADDR_W-1:0]   bus_addr,
   output logic [DATA_W-1:0]   bus_wdata,
   input  logic [DATA_W-1:0]   bus_rdata,
   input  logic                bus_ack,
   // pipeline control
   output logic                stall_if,
   output logic                stall_mem,
   output logic                bus_err
);

   localparam int          SEL_W      = DATA_W / 8;
   localparam logic [3:0]  STARVE_LIM = 4'(STARVE_MAX);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GNT_IF  = 2'd1,
      GNT_MEM = 2'd2
   } state_t;

   state_t              state_q,     state_d;
   logic [3:0]          starve_q,    starve_d;
   logic                bus_req_q,   bus_req_d;
   logic                bus_we_q,    bus_we_d;
   logic [SEL_W-1:0]    bus_sel_q,   bus_sel_d;
   logic [ADDR_W-1:0]   bus_addr_q,  bus_addr_d;
   logic [DATA_W-1:0]   bus_wdata_q, bus_wdata_d;
   logic [DATA_W-1:0]   if_rdata_q,  if_rdata_d;
   logic [DATA_W-1:0]   mem_rdata_q, mem_rdata_d;
   logic                if_ready_q,  if_ready_d;
   logic                mem_ready_q, mem_ready_d;

   // Transaction ends either by bus_ack or, when enabled, by timeout abort.
   logic                done_ack;
   logic                done_abort;

`ifdef ARB_TIMEOUT_EN
   localparam int          TMO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

   logic [TMO_W-1:0]    tmo_q,       tmo_d;
   logic                bus_err_q,   bus_err_d;

   // Abort when the cycle counter has reached its last value without ack.
   always_comb begin
      done_abort = (state_q != IDLE) && !bus_ack && (tmo_q == TMO_LAST);
   end
`else
   always_comb begin
      done_abort = 1'b0;
   end
`endif

   // Next-state, arbitration and bus-output computation.
   always_comb begin
      state_d     = state_q;
      starve_d    = starve_q;
      bus_req_d   = bus_req_q;
      bus_we_d    = bus_we_q;
      bus_sel_d   = bus_sel_q;
      bus_addr_d  = bus_addr_q;
      bus_wdata_d = bus_wdata_q;
      if_rdata_d  = if_rdata_q;
      mem_rdata_d = mem_rdata_q;
      if_ready_d  = 1'b0;
      mem_ready_d = 1'b0;
      done_ack    = 1'b0;
`ifdef ARB_TIMEOUT_EN
      tmo_d       = tmo_q;
      bus_err_d   = 1'b0;
`endif

      case (state_q)
         IDLE: begin
            // MEM wins unless IF has waited through STARVE_MAX MEM grants.
            if (mem_req && !(if_req && (starve_q == STARVE_LIM))) begin
               state_d     = GNT_MEM;
               bus_req_d   = 1'b1;
               bus_we_d    = mem_we;
               bus_sel_d   = mem_sel;
               bus_addr_d  = mem_addr;
               bus_wdata_d = mem_wdata;
               if (if_req && (starve_q < STARVE_LIM)) begin
                  starve_d = starve_q + 4'd1;
               end
`ifdef ARB_TIMEOUT_EN
               tmo_d = '0;
`endif
            end else if (if_req) begin
               state_d     = GNT_IF;
               bus_req_d   = 1'b1;
               bus_we_d    = 1'b0;
               bus_sel_d   = {SEL_W{1'b1}};
               bus_addr_d  = if_addr;
               bus_wdata_d = '0;
               starve_d    = 4'd0;
`ifdef ARB_TIMEOUT_EN
               tmo_d = '0;
`endif
            end
         end

         GNT_IF, GNT_MEM: begin
            if (bus_ack) begin
               done_ack = 1'b1;
            end
`ifdef ARB_TIMEOUT_EN
            else if (!done_abort) begin
               tmo_d = tmo_q + 1'b1;
            end
`endif
            if (done_ack || done_abort) begin
               state_d   = IDLE;
               bus_req_d = 1'b0;
               if (state_q == GNT_IF) begin
                  if_ready_d = 1'b1;
                  if_rdata_d = done_abort ? '0 : bus_rdata;
               end else begin
                  mem_ready_d = 1'b1;
                  if (done_abort) begin
                     mem_rdata_d = '0;
                  end else if (!bus_we_q) begin
                     mem_rdata_d = bus_rdata;
                  end
               end
`ifdef ARB_TIMEOUT_EN
               bus_err_d = done_abort;
`endif
            end
         end

         default: begin
            state_d   = IDLE;
            bus_req_d = 1'b0;
         end
      endcase
   end

   // State and registered outputs; reset wins even mid-transaction.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         starve_q    <= 4'd0;
         bus_req_q   <= 1'b0;
         bus_we_q    <= 1'b0;
         bus_sel_q   <= '0;
         bus_addr_q  <= '0;
         bus_wdata_q <= '0;
         if_rdata_q  <= '0;
         mem_rdata_q <= '0;
         if_ready_q  <= 1'b0;
         mem_ready_q <= 1'b0;
`ifdef ARB_TIMEOUT_EN
         tmo_q       <= '0;
         bus_err_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         starve_q    <= starve_d;
         bus_req_q   <= bus_req_d;
         bus_we_q    <= bus_we_d;
         bus_sel_q   <= bus_sel_d;
         bus_addr_q  <= bus_addr_d;
         bus_wdata_q <= bus_wdata_d;
         if_rdata_q  <= if_rdata_d;
         mem_rdata_q <= mem_rdata_d;
         if_ready_q  <= if_ready_d;
         mem_ready_q <= mem_ready_d;
`ifdef ARB_TIMEOUT_EN
         tmo_q       <= tmo_d;
         bus_err_q   <= bus_err_d;
`endif
      end
   end

   assign bus_req   = bus_req_q;
   assign bus_we    = bus_we_q;
   assign bus_sel   = bus_sel_q;
   assign bus_addr  = bus_addr_q;
   assign bus_wdata = bus_wdata_q;
   assign if_rdata  = if_rdata_q;
   assign if_ready  = if_ready_q;
   assign mem_rdata = mem_rdata_q;
   assign mem_ready = mem_ready_q;

   // Stalls release in the same cycle the registered ready pulse appears.
   assign stall_if  = if_req  & ~if_ready_q;
   assign stall_mem = mem_req & ~mem_ready_q;

`ifdef ARB_TIMEOUT_EN
   assign bus_err = bus_err_q;
`else
   assign bus_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_port_arbiter
//  Purpose  : Directed self-checking bench for mem_port_arbiter
//             (STARVE_MAX = 2, TIMEOUT = 16).
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mem_port_arbiter;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;

   logic              clk = 1'b0;
   logic              rst;
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic [DATA_W-1:0] if_rdata;
   logic              if_ready;
   logic              mem_req;
   logic              mem_we;
   logic [3:0]        mem_sel;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ready;
   logic              bus_req;
   logic              bus_we;
   logic [3:0]        bus_sel;
   logic [ADDR_W-1:0] bus_addr;
   logic [DATA_W-1:0] bus_wdata;
   logic [DATA_W-1:0] bus_rdata;
   logic              bus_ack;
   logic              stall_if;
   logic              stall_mem;
   logic              bus_err;

   int n_checks = 0;
   int n_errors = 0;

   mem_port_arbiter #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(2), .TIMEOUT(16)
   ) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
      .mem_req(mem_req), .mem_we(mem_we), .mem_sel(mem_sel), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
      .bus_req(bus_req), .bus_we(bus_we), .bus_sel(bus_sel), .bus_addr(bus_addr),
      .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
      .stall_if(stall_if), .stall_mem(stall_mem), .bus_err(bus_err)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; if_req = 1'b0; if_addr = '0; mem_req = 1'b0; mem_we = 1'b0;
      mem_sel = 4'h0; mem_addr = '0; mem_wdata = '0; bus_rdata = '0; bus_ack = 1'b0;
      tick(); tick();
      rst = 1'b0;

      // Reset state
      check_val("rst_bus_req",   bus_req,   0);
      check_val("rst_if_ready",  if_ready,  0);
      check_val("rst_mem_ready", mem_ready, 0);
      check_val("rst_if_rdata",  if_rdata,  0);
      check_val("rst_bus_addr",  bus_addr,  0);
      check_val("rst_bus_err",   bus_err,   0);

      // Single fetch
      if_req = 1'b1; if_addr = 32'h0000_0040;
      #1 check_val("fetch_stall_pre", stall_if, 1);
      tick();
      check_val("fetch_bus_req",   bus_req,   1);
      check_val("fetch_bus_addr",  bus_addr,  32'h40);
      check_val("fetch_bus_we",    bus_we,    0);
      check_val("fetch_bus_sel",   bus_sel,   4'hF);
      check_val("fetch_bus_wdata", bus_wdata, 0);
      check_val("fetch_stall",     stall_if,  1);
      check_val("fetch_no_ready",  if_ready,  0);
      bus_ack = 1'b1; bus_rdata = 32'h3C01_1234; if_req = 1'b0;
      tick();
      bus_ack = 1'b0;
      check_val("fetch_ready",     if_ready,  1);
      check_val("fetch_rdata",     if_rdata,  32'h3C01_1234);
      check_val("fetch_req_drop",  bus_req,   0);
      check_val("fetch_mem_quiet", mem_ready, 0);
      tick();
      check_val("fetch_ready_1cyc", if_ready, 0);
      check_val("fetch_idle",       bus_req,  0);

      // Data read, to preload mem_rdata
      mem_req = 1'b1; mem_we = 1'b0; mem_sel = 4'hF; mem_addr = 32'h200;
      tick();
      check_val("rd_bus_addr", bus_addr, 32'h200);
      check_val("rd_bus_we",   bus_we,   0);
      bus_ack = 1'b1; bus_rdata = 32'h1122_3344; mem_req = 1'b0;
      tick();
      bus_ack = 1'b0;
      check_val("rd_ready", mem_ready, 1);
      check_val("rd_rdata", mem_rdata, 32'h1122_3344);
      tick();

      // Data write with one wait cycle
      mem_req = 1'b1; mem_we = 1'b1; mem_sel = 4'b0011; mem_addr = 32'h100;
      mem_wdata = 32'hDEAD_BEEF;
      tick();
      check_val("wr_bus_req",   bus_req,   1);
      check_val("wr_bus_we",    bus_we,    1);
      check_val("wr_bus_sel",   bus_sel,   4'b0011);
      check_val("wr_bus_addr",  bus_addr,  32'h100);
      check_val("wr_bus_wdata", bus_wdata, 32'hDEAD_BEEF);
      tick();
      check_val("wr_wait_req",   bus_req,   1);
      check_val("wr_wait_stall", stall_mem, 1);
      bus_ack = 1'b1; bus_rdata = 32'hFFFF_FFFF; mem_req = 1'b0;
      tick();
      bus_ack = 1'b0;
      check_val("wr_ready",     mem_ready, 1);
      check_val("wr_rdata_kept", mem_rdata, 32'h1122_3344);
      tick();
      check_val("wr_ready_1cyc", mem_ready, 0);

      // Ack while idle
      bus_ack = 1'b1;
      tick();
      check_val("idle_ack_if",  if_ready,  0);
      check_val("idle_ack_mem", mem_ready, 0);
      check_val("idle_ack_req", bus_req,   0);
      bus_ack = 1'b0;
      tick();
      check_val("idle_ack_req2", bus_req, 0);

      // Contention: expected grant order MEM, MEM, IF, MEM, MEM, IF
      if_req = 1'b1; if_addr = 32'h80;
      mem_req = 1'b1; mem_we = 1'b0; mem_sel = 4'hF; mem_addr = 32'h300;
      for (int k = 0; k < 6; k++) begin
         logic        exp_mem;
         logic [31:0] dat;
         exp_mem = ((k % 3) != 2);
         dat     = 32'hA000_0000 + 32'(k);
         tick();
         check_val($sformatf("cont%0d_req", k),  bus_req, 1);
         check_val($sformatf("cont%0d_addr", k), bus_addr, exp_mem ? 32'h300 : 32'h80);
         bus_ack = 1'b1; bus_rdata = dat;
         if (k == 5) begin
            if_req = 1'b0; mem_req = 1'b0;
         end
         tick();
         bus_ack = 1'b0;
         check_val($sformatf("cont%0d_gap", k),   bus_req,   0);
         check_val($sformatf("cont%0d_memrdy", k), mem_ready, exp_mem);
         check_val($sformatf("cont%0d_ifrdy", k),  if_ready,  !exp_mem);
         check_val($sformatf("cont%0d_data", k), exp_mem ? mem_rdata : if_rdata, dat);
      end
      tick();
      check_val("cont_end_idle", bus_req, 0);

      // Reset mid-transaction, then a late ack
      mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h400;
      tick();
      check_val("mrst_granted", bus_req, 1);
      rst = 1'b1; mem_req = 1'b0;
      tick();
      check_val("mrst_req",    bus_req,   0);
      check_val("mrst_addr",   bus_addr,  0);
      check_val("mrst_rdata",  mem_rdata, 0);
      check_val("mrst_ifdata", if_rdata,  0);
      rst = 1'b0; bus_ack = 1'b1; bus_rdata = 32'h5555_AAAA;
      tick();
      bus_ack = 1'b0;
      check_val("mrst_late_mem", mem_ready, 0);
      check_val("mrst_late_if",  if_ready,  0);
      check_val("mrst_late_dat", mem_rdata, 0);
      tick();

`ifdef ARB_TIMEOUT_EN
      // Timeout abort: 16 GNT cycles without ack, then pending MEM is granted
      if_req = 1'b1; if_addr = 32'h44; bus_rdata = 32'h7777_7777;
      tick();
      check_val("tmo_granted", bus_req, 1);
      if_req = 1'b0; mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h500;
      for (int c = 0; c < 15; c++) begin
         tick();
         check_val($sformatf("tmo_wait%0d", c), bus_req | (if_ready << 1) | (bus_err << 2), 1);
      end
      tick();
      check_val("tmo_if_ready", if_ready, 1);
      check_val("tmo_bus_err",  bus_err,  1);
      check_val("tmo_if_rdata", if_rdata, 0);
      check_val("tmo_req_drop", bus_req,  0);
      tick();
      check_val("tmo_err_1cyc", bus_err,  0);
      check_val("tmo_next_gnt", bus_req,  1);
      check_val("tmo_next_adr", bus_addr, 32'h500);
      bus_ack = 1'b1; bus_rdata = 32'h0BAD_F00D; mem_req = 1'b0;
      tick();
      bus_ack = 1'b0;
      check_val("tmo_next_rdy", mem_ready, 1);
      check_val("tmo_next_dat", mem_rdata, 32'h0BAD_F00D);
      check_val("tmo_next_err", bus_err,   0);
      tick();
`else
      // Without the timeout option a stuck bus simply waits; bus_err stays low
      mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h600;
      tick();
      for (int c = 0; c < 20; c++) tick();
      check_val("notmo_still_req", bus_req,   1);
      check_val("notmo_no_ready",  mem_ready, 0);
      check_val("notmo_no_err",    bus_err,   0);
      bus_ack = 1'b1; bus_rdata = 32'h1357_9BDF; mem_req = 1'b0;
      tick();
      bus_ack = 1'b0;
      check_val("notmo_ready", mem_ready, 1);
      check_val("notmo_data",  mem_rdata, 32'h1357_9BDF);
      tick();
`endif

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single external memory bus between instruction fetch (IF port) and data access (MEM port) of the MIPS core.
- Sits between the pipeline and the unified memory.
- Grants one port at a time and drives registered bus transactions.
- Returns read data with a one-cycle ready pulse and generates the IF/MEM stall signals for the pipeline controller.

Parameters:
- ADDR_W, 32, address width of ports and bus
- DATA_W, 32, data width of ports and bus
- STARVE_MAX, 2, consecutive MEM grants allowed while IF is waiting before IF is forced a grant (1..15)
- TIMEOUT, 16, bus cycles waited for bus_ack before abort (used only with the optional feature)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- if_req  in  1  fetch request, held until if_ready
- if_addr  in  ADDR_W  fetch address
- if_rdata  out  DATA_W  fetched instruction
- if_ready  out  1  one-cycle pulse, if_rdata valid
- mem_req  in  1  data request, held until mem_ready
- mem_we  in  1  1=write, 0=read
- mem_sel  in  DATA_W/8  byte enables
- mem_addr  in  ADDR_W  data address
- mem_wdata  in  DATA_W  write data
- mem_rdata  out  DATA_W  read data
- mem_ready  out  1  one-cycle pulse, access complete
- bus_req  out  1  bus cycle active
- bus_we  out  1  bus write
- bus_sel  out  DATA_W/8  bus byte enables
- bus_addr  out  ADDR_W  bus address
- bus_wdata  out  DATA_W  bus write data
- bus_rdata  in  DATA_W  bus read data
- bus_ack  in  1  transfer complete, sampled while bus_req=1
- stall_if  out  1  IF must hold
- stall_mem  out  1  MEM must hold
- bus_err  out  1  one-cycle pulse on timeout abort

Behaviour:
- Reset: rst=1 at the clock edge clears all registered outputs to 0, clears the state to IDLE and clears starve_cnt. Effective mid-transaction: bus_req drops at that edge, and any later bus_ack is ignored.
- States: IDLE, GNT_IF, GNT_MEM.
- IDLE arbitration, one decision per cycle:
  - If mem_req and not (if_req and starve_cnt==STARVE_MAX), go to GNT_MEM.
  - Else if if_req, go to GNT_IF.
  - Else stay in IDLE.
- On entering a GNT state, the bus outputs are registered from the granted port: addr, we, sel, wdata. For IF: we=0, sel all ones, wdata=0. bus_req=1. Outputs stay stable until ack.
- In a GNT state with bus_ack=1:
  - bus_req goes to 0 at the next edge.
  - State returns to IDLE.
  - The granted port's ready pulses 1 for exactly one cycle.
  - On reads, bus_rdata is captured into if_rdata or mem_rdata. Writes leave mem_rdata unchanged.
- bus_ack while in IDLE is ignored.
- Latency:
  - Request first seen at edge N: bus_req=1 after N, ack sampled at edge N+k (k≥1), ready=1 during cycle after N+k.
  - Minimum 2 cycles request-to-ready.
  - One mandatory IDLE turnaround cycle between transactions; back-to-back grants are never issued without it.
- starve_cnt:
  - Increments, saturating at STARVE_MAX, on each MEM grant taken while if_req=1.
  - Clears to 0 on every IF grant.
  - Unchanged otherwise.
- Stalls: stall_if = if_req & ~if_ready; stall_mem = mem_req & ~mem_ready. Combinational from registered ready.
- Requester protocol:
  - Requests and payloads are held stable until ready.
  - If a requester drops req mid-transaction, the bus cycle still completes and ready still pulses. This is a legal but wasted access.
- Simultaneous if_req and mem_req with starve_cnt<STARVE_MAX: MEM wins, because it is the older instruction.
- Address/data are passed unmodified. No alignment checking.

Optional Feature:
ARB_TIMEOUT_EN
- Defined:
  - A counter loads 0 on grant and increments each GNT cycle without ack.
  - When it reaches TIMEOUT-1 without ack, bus_req drops at the next edge and the state returns to IDLE.
  - The granted port's ready pulses with rdata forced to 0, and bus_err pulses 1 in the same cycle.
  - starve_cnt updates as for a normal completion.
- Not defined: no counter. The arbiter waits forever for bus_ack, and bus_err is tied 0.

Test Plan:
- Single fetch: if_req=1, if_addr=0x0000_0040, bus_ack one cycle after bus_req with bus_rdata=0x3C01_1234 -> bus_addr=0x40, bus_we=0; if_ready pulses once with if_rdata=0x3C01_1234; stall_if=1 until then.
- Data write: mem_req=1, mem_we=1, mem_sel=4'b0011, mem_addr=0x100, mem_wdata=0xDEAD_BEEF -> bus outputs match; mem_ready pulses; mem_rdata unchanged.
- Contention with STARVE_MAX=2: if_req and mem_req both held high continuously -> grant order MEM, MEM, IF, MEM, MEM, IF; IDLE gap between each.
- Reset mid-transaction: rst asserted while in GNT_MEM before ack -> bus_req=0 next cycle; a late bus_ack produces no ready pulse; all outputs 0.
- Ack in IDLE: bus_ack=1 with no grant -> no ready pulse, no state change.
- ARB_TIMEOUT_EN with TIMEOUT=16: bus_ack never asserted -> after 16 GNT cycles bus_err and if_ready pulse together, if_rdata=0, and the next pending request is granted.
